hazard_scoreboard: RTL and testbench

HAZARD_SCOREBOARD -- requirements
Module: hazard_scoreboard

---
 rtl/hazard_pkg.sv | 22 ++
 rtl/bypass_sel.sv | 34 +++
 rtl/hazard_scoreboard.sv | 123 ++++++++++++
 tb/tb_hazard_scoreboard.sv | 292 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// Shared encodings and pipeline latch-control constants for the hazard scoreboard.
// The bypass encodings are consumed by the EXE operand muxes outside this block.
package hazard_pkg;

    typedef enum logic [1:0] {
        SEL_RF = 2'b00,
        SEL_W  = 2'b01,
        SEL_M  = 2'b10
    } alu_src_sel_e;

    typedef struct packed {
        logic en_f;
        logic en_d;
        logic clear_d;
    } latch_ctrl_t;

    // Normal flow, hazard hold, and branch/jump flush of the front end.
    localparam latch_ctrl_t LATCH_RUN   = '{en_f: 1'b1, en_d: 1'b1, clear_d: 1'b0};
    localparam latch_ctrl_t LATCH_HOLD  = '{en_f: 1'b0, en_d: 1'b0, clear_d: 1'b0};
    localparam latch_ctrl_t LATCH_FLUSH = '{en_f: 1'b1, en_d: 1'b1, clear_d: 1'b1};

endpackage

// File: rtl/bypass_sel.sv
// Forwarding select for one EXE source operand: MEM result beats WB result, x0 never forwards.
// Purely combinational so the operand mux settles in the same cycle.
module bypass_sel
    import hazard_pkg::*;
#(
    parameter int ADDR_W        = 5,
    parameter int ALU_SRC_SEL_W = 2
) (
    input  logic [ADDR_W-1:0]        rf_src_i,
    input  logic [ADDR_W-1:0]        rf_dst_m_i,
    input  logic                     rf_we_m_i,
    input  logic [ADDR_W-1:0]        rf_dst_w_i,
    input  logic                     rf_we_w_i,
    output logic [ALU_SRC_SEL_W-1:0] alu_src_sel_o
);

    alu_src_sel_e sel;
    logic         src_nz;

    assign src_nz = (rf_src_i != '0);

    // NOTE: every signal written in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        sel = SEL_RF;
        if (src_nz && rf_we_m_i && (rf_src_i == rf_dst_m_i)) begin
            sel = SEL_M;
        end else if (src_nz && rf_we_w_i && (rf_src_i == rf_dst_w_i)) begin
            sel = SEL_W;
        end
    end

    assign alu_src_sel_o = ALU_SRC_SEL_W'(sel);

endmodule

// File: rtl/hazard_scoreboard.sv
// Pipeline hazard unit: EXE bypass selects, long-latency pending scoreboard, RAW/WAW stall,
// redirect flush control and a saturating stall-cycle counter.
module hazard_scoreboard
    import hazard_pkg::*;
#(
    parameter int ADDR_W        = 5,
    parameter int NUM_SRC       = 2,
    parameter int ALU_SRC_SEL_W = 2,
    parameter int CNT_W         = 16
) (
    input  logic                             clk_i,
    input  logic                             rst_n_i,
    input  logic [NUM_SRC*ADDR_W-1:0]        rf_src_e_i,
    input  logic [ADDR_W-1:0]                rf_dst_m_i,
    input  logic                             rf_we_m_i,
    input  logic [ADDR_W-1:0]                rf_dst_w_i,
    input  logic                             rf_we_w_i,
    output logic [NUM_SRC*ALU_SRC_SEL_W-1:0] alu_src_sel_o,
    input  logic [NUM_SRC*ADDR_W-1:0]        rf_src_d_i,
    input  logic [NUM_SRC-1:0]               src_used_d_i,
    input  logic [ADDR_W-1:0]                rf_dst_d_i,
    input  logic                             rf_we_d_i,
    input  logic [ADDR_W-1:0]                rf_dst_e_i,
    input  logic                             mem2rf_e_i,
    input  logic                             long_issue_e_i,
    input  logic                             long_done_i,
    input  logic [ADDR_W-1:0]                long_dst_i,
    input  logic                             redirect_e_i,
    output logic                             latch_en_f_o,
    output logic                             latch_clear_d_o,
    output logic                             latch_en_d_o,
    output logic                             busy_o,
    output logic [CNT_W-1:0]                 stall_cnt_o
);

    localparam int              NREG    = 1 << ADDR_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [NREG-1:0]    pending_q;
    logic [NREG-1:0]    pending_d;
    logic               busy_q;
    logic [CNT_W-1:0]   stall_cnt_q;
    logic [NUM_SRC-1:0] raw_hit;
    logic               waw_hit;
    logic               hazard;
    logic               stall;
    latch_ctrl_t        ctrl;

    // Per-port forwarding and RAW detection share the same generate loop.
    for (genvar k = 0; k < NUM_SRC; k++) begin : g_port
        logic [ADDR_W-1:0] src_d;
        logic              exe_hit;

        assign src_d   = rf_src_d_i[k*ADDR_W +: ADDR_W];
        // A load or a long op in EXE cannot forward in time; its destination is not yet valid.
        assign exe_hit = (src_d == rf_dst_e_i) && (mem2rf_e_i || long_issue_e_i);
        assign raw_hit[k] = src_used_d_i[k] && (src_d != '0) && (exe_hit || pending_q[src_d]);

        bypass_sel #(
            .ADDR_W        (ADDR_W),
            .ALU_SRC_SEL_W (ALU_SRC_SEL_W)
        ) u_bypass_sel (
            .rf_src_i      (rf_src_e_i[k*ADDR_W +: ADDR_W]),
            .rf_dst_m_i    (rf_dst_m_i),
            .rf_we_m_i     (rf_we_m_i),
            .rf_dst_w_i    (rf_dst_w_i),
            .rf_we_w_i     (rf_we_w_i),
            .alu_src_sel_o (alu_src_sel_o[k*ALU_SRC_SEL_W +: ALU_SRC_SEL_W])
        );
    end

    assign waw_hit = rf_we_d_i && (rf_dst_d_i != '0) && pending_q[rf_dst_d_i];
    assign hazard  = (|raw_hit) || waw_hit;
    assign stall   = hazard && !redirect_e_i;

    // Clear is applied before set so a same-cycle issue to a retiring register keeps it pending.
    always_comb begin
        pending_d = pending_q;
        if (long_done_i) begin
            pending_d[long_dst_i] = 1'b0;
        end
        if (long_issue_e_i && (rf_dst_e_i != '0)) begin
            pending_d[rf_dst_e_i] = 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    // NOTE: the pending vector is reset explicitly; stale bits would stall forever after reset.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            pending_q <= '0;
            busy_q    <= 1'b0;
        end else begin
            pending_q <= pending_d;
            busy_q    <= |pending_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            stall_cnt_q <= '0;
        end else if (stall && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_q <= stall_cnt_q + CNT_W'(1);
        end
    end

    // Redirect flushes DE regardless of any hazard on the wrong-path instruction.
    always_comb begin
        ctrl = LATCH_RUN;
        if (redirect_e_i) begin
            ctrl = LATCH_FLUSH;
        end else if (hazard) begin
            ctrl = LATCH_HOLD;
        end
    end

    assign latch_en_f_o    = ctrl.en_f;
    assign latch_en_d_o    = ctrl.en_d;
    assign latch_clear_d_o = ctrl.clear_d;
    assign busy_o          = busy_q;
    assign stall_cnt_o     = stall_cnt_q;

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Self-checking bench: directed scenarios with literal expectations plus randomized traffic
// compared every cycle against a register-array model of the scoreboard rules.
module tb_hazard_scoreboard;

    localparam int ADDR_W  = 5;
    localparam int NUM_SRC = 2;
    localparam int SEL_W   = 2;
    localparam int CNT_W   = 5;
    localparam int NREG    = 1 << ADDR_W;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic                       clk_i = 1'b0;
    logic                       rst_n_i = 1'b0;
    logic [NUM_SRC*ADDR_W-1:0]  rf_src_e_i;
    logic [ADDR_W-1:0]          rf_dst_m_i;
    logic                       rf_we_m_i;
    logic [ADDR_W-1:0]          rf_dst_w_i;
    logic                       rf_we_w_i;
    logic [NUM_SRC*SEL_W-1:0]   alu_src_sel_o;
    logic [NUM_SRC*ADDR_W-1:0]  rf_src_d_i;
    logic [NUM_SRC-1:0]         src_used_d_i;
    logic [ADDR_W-1:0]          rf_dst_d_i;
    logic                       rf_we_d_i;
    logic [ADDR_W-1:0]          rf_dst_e_i;
    logic                       mem2rf_e_i;
    logic                       long_issue_e_i;
    logic                       long_done_i;
    logic [ADDR_W-1:0]          long_dst_i;
    logic                       redirect_e_i;
    logic                       latch_en_f_o;
    logic                       latch_clear_d_o;
    logic                       latch_en_d_o;
    logic                       busy_o;
    logic [CNT_W-1:0]           stall_cnt_o;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    bit m_pending [NREG];
    int m_cnt;

    hazard_scoreboard #(
        .ADDR_W        (ADDR_W),
        .NUM_SRC       (NUM_SRC),
        .ALU_SRC_SEL_W (SEL_W),
        .CNT_W         (CNT_W)
    ) dut (
        .clk_i           (clk_i),
        .rst_n_i         (rst_n_i),
        .rf_src_e_i      (rf_src_e_i),
        .rf_dst_m_i      (rf_dst_m_i),
        .rf_we_m_i       (rf_we_m_i),
        .rf_dst_w_i      (rf_dst_w_i),
        .rf_we_w_i       (rf_we_w_i),
        .alu_src_sel_o   (alu_src_sel_o),
        .rf_src_d_i      (rf_src_d_i),
        .src_used_d_i    (src_used_d_i),
        .rf_dst_d_i      (rf_dst_d_i),
        .rf_we_d_i       (rf_we_d_i),
        .rf_dst_e_i      (rf_dst_e_i),
        .mem2rf_e_i      (mem2rf_e_i),
        .long_issue_e_i  (long_issue_e_i),
        .long_done_i     (long_done_i),
        .long_dst_i      (long_dst_i),
        .redirect_e_i    (redirect_e_i),
        .latch_en_f_o    (latch_en_f_o),
        .latch_clear_d_o (latch_clear_d_o),
        .latch_en_d_o    (latch_en_d_o),
        .busy_o          (busy_o),
        .stall_cnt_o     (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [1:0] exp_sel(input int k);
        int s;
        s = int'(rf_src_e_i[k*ADDR_W +: ADDR_W]);
        if (s != 0 && rf_we_m_i && s == int'(rf_dst_m_i)) return 2'b10;
        if (s != 0 && rf_we_w_i && s == int'(rf_dst_w_i)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic bit exp_hazard();
        bit h;
        h = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            int s;
            s = int'(rf_src_d_i[k*ADDR_W +: ADDR_W]);
            if (src_used_d_i[k] && s != 0) begin
                if (s == int'(rf_dst_e_i) && (mem2rf_e_i || long_issue_e_i)) h = 1'b1;
                if (m_pending[s]) h = 1'b1;
            end
        end
        if (rf_we_d_i && rf_dst_d_i != 0 && m_pending[rf_dst_d_i]) h = 1'b1;
        return h;
    endfunction

    function automatic bit exp_busy();
        for (int i = 0; i < NREG; i++) if (m_pending[i]) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < NREG; i++) m_pending[i] <= 1'b0;
            m_cnt <= 0;
        end else begin
            if (long_done_i) m_pending[long_dst_i] <= 1'b0;
            if (long_issue_e_i && rf_dst_e_i != 0) m_pending[rf_dst_e_i] <= 1'b1;
            if (exp_hazard() && !redirect_e_i && m_cnt < CNT_MAX) m_cnt <= m_cnt + 1;
        end
    end

    always @(negedge clk_i) begin
        if (cmp_en) begin
            bit st;
            st = exp_hazard() && !redirect_e_i;
            for (int k = 0; k < NUM_SRC; k++)
                check($sformatf("sel%0d", k), 32'(alu_src_sel_o[k*SEL_W +: SEL_W]), 32'(exp_sel(k)));
            check("latch_en_f", 32'(latch_en_f_o), 32'(!st));
            check("latch_en_d", 32'(latch_en_d_o), 32'(!st));
            check("latch_clear_d", 32'(latch_clear_d_o), 32'(redirect_e_i));
            check("busy", 32'(busy_o), 32'(exp_busy()));
            check("stall_cnt", 32'(stall_cnt_o), 32'(m_cnt));
        end
    end

    // ---------------- stimulus helpers ----------------
    function automatic logic [NUM_SRC*ADDR_W-1:0] pack2(input int p1, input int p0);
        return {ADDR_W'(p1), ADDR_W'(p0)};
    endfunction

    task automatic idle();
        rf_src_e_i = '0; rf_dst_m_i = '0; rf_we_m_i = 1'b0; rf_dst_w_i = '0; rf_we_w_i = 1'b0;
        rf_src_d_i = '0; src_used_d_i = '0; rf_dst_d_i = '0; rf_we_d_i = 1'b0;
        rf_dst_e_i = '0; mem2rf_e_i = 1'b0; long_issue_e_i = 1'b0;
        long_done_i = 1'b0; long_dst_i = '0; redirect_e_i = 1'b0;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        idle();
        #2;
        check("reset busy", 32'(busy_o), 32'd0);
        check("reset cnt", 32'(stall_cnt_o), 32'd0);
        check("reset en_f", 32'(latch_en_f_o), 32'd1);
        step();
        rst_n_i = 1'b1;
        cmp_en  = 1'b1;
        step();

        // Forwarding priority: MEM over WB, x0 never forwarded.
        rf_src_e_i = pack2(0, 3); rf_dst_m_i = 3; rf_we_m_i = 1; rf_dst_w_i = 3; rf_we_w_i = 1;
        #1 check("fwd mem prio", 32'(alu_src_sel_o[1:0]), 32'h2);
        check("fwd x0 port1", 32'(alu_src_sel_o[3:2]), 32'h0);
        rf_we_m_i = 0;
        #1 check("fwd wb", 32'(alu_src_sel_o[1:0]), 32'h1);
        step();

        // Long-latency op to x7: stalls until the cycle after its completion.
        idle();
        rf_dst_e_i = 7; long_issue_e_i = 1; rf_src_d_i = pack2(0, 7); src_used_d_i = 2'b01;
        #1 check("x7 issue stall", 32'(latch_en_f_o), 32'd0);
        step();
        long_issue_e_i = 0;
        #1 check("x7 pending stall", 32'(latch_en_d_o), 32'd0);
        check("x7 busy", 32'(busy_o), 32'd1);
        step(); step();
        long_done_i = 1; long_dst_i = 7;
        #1 check("x7 done-cycle stall", 32'(latch_en_f_o), 32'd0);
        step();
        long_done_i = 0;
        #1 check("x7 released", 32'(latch_en_f_o), 32'd1);
        check("x7 not busy", 32'(busy_o), 32'd0);
        step();

        // Load-use on port 1: only when the operand is actually used.
        idle();
        mem2rf_e_i = 1; rf_dst_e_i = 5; rf_src_d_i = pack2(5, 0); src_used_d_i = 2'b01;
        #1 check("load unused", 32'(latch_en_f_o), 32'd1);
        src_used_d_i = 2'b11;
        #1 check("load-use stall", 32'(latch_en_f_o), 32'd0);
        step();
        mem2rf_e_i = 0; rf_dst_e_i = 0;
        #1 check("load-use one cycle", 32'(latch_en_f_o), 32'd1);
        step();

        // WAW against pending x9, then redirect overriding it.
        idle();
        rf_dst_e_i = 9; long_issue_e_i = 1;
        step();
        idle();
        rf_dst_d_i = 9; rf_we_d_i = 1;
        #1 check("waw stall", 32'(latch_en_f_o), 32'd0);
        check("waw no clear", 32'(latch_clear_d_o), 32'd0);
        redirect_e_i = 1;
        #1 check("redirect clear", 32'(latch_clear_d_o), 32'd1);
        check("redirect en_f", 32'(latch_en_f_o), 32'd1);
        step();
        idle();
        long_done_i = 1; long_dst_i = 9;
        step();

        // Same-cycle set and clear of x4: set wins.
        idle();
        rf_dst_e_i = 4; long_issue_e_i = 1; long_done_i = 1; long_dst_i = 4;
        step();
        idle();
        #1 check("set wins busy", 32'(busy_o), 32'd1);
        rf_src_d_i = pack2(0, 4); src_used_d_i = 2'b01;
        #1 check("set wins stall", 32'(latch_en_f_o), 32'd0);
        step();

        // Reset with x4 pending and counter at 12.
        idle();
        rst_n_i = 1'b0;
        #1 rst_n_i = 1'b1;
        rf_dst_e_i = 4; long_issue_e_i = 1;
        step();
        idle();
        rf_src_d_i = pack2(0, 4); src_used_d_i = 2'b01;
        for (int i = 0; i < 12; i++) step();
        check("cnt twelve", 32'(stall_cnt_o), 32'd12);
        check("busy before reset", 32'(busy_o), 32'd1);
        rst_n_i = 1'b0;
        #1 check("async reset cnt", 32'(stall_cnt_o), 32'd0);
        check("async reset busy", 32'(busy_o), 32'd0);
        check("async reset no stall", 32'(latch_en_f_o), 32'd1);
        #1 rst_n_i = 1'b1;
        idle();
        long_done_i = 1; long_dst_i = 4;
        step();
        long_done_i = 0;
        #1 check("stale done harmless", 32'(busy_o), 32'd0);

        // Counter saturation.
        rf_dst_e_i = 4; long_issue_e_i = 1;
        step();
        idle();
        rf_src_d_i = pack2(4, 0); src_used_d_i = 2'b10;
        for (int i = 0; i < CNT_MAX + 8; i++) step();
        check("cnt saturated", 32'(stall_cnt_o), 32'(CNT_MAX));
        idle();
        long_done_i = 1; long_dst_i = 4;
        step();
        rst_n_i = 1'b0;
        #1 rst_n_i = 1'b1;

        // Randomized traffic, addresses kept small to provoke collisions.
        for (int i = 0; i < 3000; i++) begin
            rf_src_e_i     = pack2($urandom_range(0, 7), $urandom_range(0, 7));
            rf_dst_m_i     = ADDR_W'($urandom_range(0, 7));
            rf_we_m_i      = 1'($urandom_range(0, 1));
            rf_dst_w_i     = ADDR_W'($urandom_range(0, 7));
            rf_we_w_i      = 1'($urandom_range(0, 1));
            rf_src_d_i     = pack2($urandom_range(0, 7), $urandom_range(0, 7));
            src_used_d_i   = 2'($urandom_range(0, 3));
            rf_dst_d_i     = ADDR_W'($urandom_range(0, 7));
            rf_we_d_i      = 1'($urandom_range(0, 1));
            rf_dst_e_i     = ADDR_W'($urandom_range(0, 7));
            mem2rf_e_i     = ($urandom_range(0, 3) == 0);
            long_issue_e_i = ($urandom_range(0, 7) == 0);
            long_done_i    = ($urandom_range(0, 2) == 0);
            long_dst_i     = ADDR_W'($urandom_range(0, 7));
            redirect_e_i   = ($urandom_range(0, 9) == 0);
            if (i % 500 == 499) begin
                rst_n_i = 1'b0;
                #1 rst_n_i = 1'b1;
            end
            step();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
